first_nios2_system_sysid_checker: RTL and testbench

Boot-time sequencer for the system-ID slave. After reset, or on request, it issues two Avalon-MM reads: word 0 (system ID) and word 1 (build timestamp). It compares both values against expected constants and reports pass/fail/timeout to the CPU-side status logic. It sits between the reset controller and the sysid slave, and it is the only master on the slave's control port.

---
 rtl/first_nios2_system_sysid_checker_pkg.sv | 22 ++
 rtl/first_nios2_system_sysid_checker_wait_timer.sv | 29 ++
 rtl/first_nios2_system_sysid_checker.sv | 146 ++++++++++++++
 tb/tb_first_nios2_system_sysid_checker.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/first_nios2_system_sysid_checker_pkg.sv
// Shared types and constants for the system-ID boot checker.
package first_nios2_system_sysid_checker_pkg;

   // Sequencer states: two reads, one compare, then back to idle.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_ID = 2'd1,
      RD_TS = 2'd2,
      CMP   = 2'd3
   } state_t;

   // Word selects on the sysid slave control port.
   localparam logic SYSID_WORD_ID = 1'b0;
   localparam logic SYSID_WORD_TS = 1'b1;

   // Build timestamp this image was generated with.
   localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1363472126;

   // Width of the per-read wait-state counter.
   localparam int WAIT_W = 16;

endpackage

// File: rtl/first_nios2_system_sysid_checker_wait_timer.sv
// Counts consecutive wait-state cycles of one read and flags the cycle on
// which the stall budget is used up.
module first_nios2_system_sysid_wait_timer
   import first_nios2_system_sysid_checker_pkg::*;
#(
   parameter int unsigned LIMIT = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [WAIT_W-1:0] count;

   // Clear wins over counting so every new read starts from zero.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   // The LIMIT-th stalled cycle is the last one tolerated.
   assign expired = enable && (count == WAIT_W'(LIMIT - 1));

endmodule

// File: rtl/first_nios2_system_sysid_checker.sv
// Boot-time sequencer: reads sysid word 0 and word 1, compares them with the
// expected constants and reports pass/fail/timeout.
//
// Avalon-MM read handshake: avm_read with a stable avm_address is held from
// registered state until a cycle with avm_waitrequest=0; in that cycle
// avm_readdata is captured and the read completes. While avm_waitrequest=1
// nothing changes on the request side.
module first_nios2_system_sysid_checker
   import first_nios2_system_sysid_checker_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
   parameter int unsigned TIMEOUT_CYCLES     = 255,
   parameter logic        AUTO_START         = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout_err,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   state_t state, state_next;
   logic   pending;
   logic   launch;
   logic   wait_en;
   logic   wait_clr;
   logic   expired;

   first_nios2_system_sysid_wait_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (wait_clr),
      .enable  (wait_en),
      .expired (expired)
   );

   // Next-state decode; a start coinciding with the done pulse is dropped.
   always_comb begin
      state_next = state;
      launch     = 1'b0;
      wait_en    = 1'b0;
      case (state)
         IDLE: begin
            if (pending || (start && !done)) begin
               state_next = RD_ID;
               launch     = 1'b1;
            end
         end
         RD_ID: begin
            wait_en = avm_waitrequest;
            if (!avm_waitrequest) begin
               state_next = RD_TS;
            end else if (expired) begin
               state_next = IDLE;
            end
         end
         RD_TS: begin
            wait_en = avm_waitrequest;
            if (!avm_waitrequest) begin
               state_next = CMP;
            end else if (expired) begin
               state_next = IDLE;
            end
         end
         CMP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign wait_clr = (state_next != state);

   // State register and the one-shot auto-start request.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         pending <= AUTO_START;
      end else begin
         state <= state_next;
         if (launch) begin
            pending <= 1'b0;
         end
      end
   end

   // Capture read data on each completed read.
   always_ff @(posedge clock) begin
      if (reset) begin
         id_value <= '0;
         ts_value <= '0;
      end else begin
         if (state == RD_ID && !avm_waitrequest) begin
            id_value <= avm_readdata;
         end
         if (state == RD_TS && !avm_waitrequest) begin
            ts_value <= avm_readdata;
         end
      end
   end

   // Status flags: cleared at launch, set at compare or abort.
   always_ff @(posedge clock) begin
      if (reset) begin
         done        <= 1'b0;
         id_ok       <= 1'b0;
         ts_ok       <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         done <= 1'b0;
         if (launch) begin
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
         end
         if (state == CMP) begin
            id_ok <= (id_value == EXPECTED_ID);
            ts_ok <= (ts_value == EXPECTED_TIMESTAMP);
            done  <= 1'b1;
         end
         if (expired) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
         end
      end
   end

   assign avm_read    = (state == RD_ID) || (state == RD_TS);
   assign avm_address = (state == RD_TS) ? SYSID_WORD_TS : SYSID_WORD_ID;
   assign busy        = (state != IDLE);

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Self-checking bench for the sysid boot checker with a behavioural slave.
module tb_first_nios2_system_sysid_checker;

  localparam logic [31:0] EXP_TS = 32'd1363472126;
  localparam int W = 83;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout_err;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  logic [31:0] slave_id;
  logic [31:0] slave_ts;
  int          stall_n;
  logic        stuck_ts;
  int          stall_cnt = 0;
  int          cyc = 0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [W-1:0] exp_q[$];

  first_nios2_system_sysid_checker #(
    .TIMEOUT_CYCLES (8),
    .AUTO_START     (1'b1)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .busy            (busy),
    .done            (done),
    .id_ok           (id_ok),
    .ts_ok           (ts_ok),
    .timeout_err     (timeout_err),
    .id_value        (id_value),
    .ts_value        (ts_value)
  );

  // clock / reset block
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  // behavioural sysid slave with programmable stalls
  assign avm_readdata    = avm_address ? slave_ts : slave_id;
  assign avm_waitrequest = avm_read && ((stuck_ts && avm_address) || (stall_cnt < stall_n));

  always @(posedge clock) begin
    if (avm_read && avm_waitrequest) stall_cnt <= stall_cnt + 1;
    else stall_cnt <= 0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic push_exp(input int dcyc, input logic to, input logic iok, input logic tok,
                          input logic [31:0] idv, input logic [31:0] tsv);
    exp_q.push_back({16'(dcyc), to, iok, tok, idv, tsv});
  endtask

  task automatic pulse_start(output int k);
    @(posedge clock); #1;
    start = 1'b1;
    k = cyc;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    push_exp(cyc + 4, 1'b0, 1'b1, 1'b1, 32'd0, EXP_TS);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clock);
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_busy"}, 64'(busy), 64'd0);
    check({pfx, "_read"}, 64'(avm_read), 64'd0);
    check({pfx, "_addr"}, 64'(avm_address), 64'd0);
    check({pfx, "_done"}, 64'(done), 64'd0);
    check({pfx, "_id_ok"}, 64'(id_ok), 64'd0);
    check({pfx, "_ts_ok"}, 64'(ts_ok), 64'd0);
    check({pfx, "_tmo"}, 64'(timeout_err), 64'd0);
    check({pfx, "_id_value"}, 64'(id_value), 64'd0);
    check({pfx, "_ts_value"}, 64'(ts_value), 64'd0);
  endtask

  // scoreboard: compare each done pulse against the oldest expectation
  always @(negedge clock) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'(done), 64'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("done_cycle", 64'(16'(cyc)), 64'(e[82:67]));
        check("timeout_err", 64'(timeout_err), 64'(e[66]));
        check("id_ok", 64'(id_ok), 64'(e[65]));
        check("ts_ok", 64'(ts_ok), 64'(e[64]));
        check("id_value", 64'(id_value), 64'(e[63:32]));
        check("ts_value", 64'(ts_value), 64'(e[31:0]));
      end
    end
  end

  initial begin
    int k;
    reset    = 1'b1;
    start    = 1'b0;
    slave_id = 32'd0;
    slave_ts = EXP_TS;
    stall_n  = 0;
    stuck_ts = 1'b0;

    // reset values, then the auto-start check
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_state("rst");
    release_reset();
    drain();

    // zero-wait, wrong timestamp
    slave_ts = 32'h1234_5678;
    push_exp(cyc + 2, 1'b0, 1'b1, 1'b0, 32'd0, 32'h1234_5678);
    pulse_start(k);
    exp_q[exp_q.size()-1][82:67] = 16'(k + 4);
    @(negedge clock);
    check("zw_read1", 64'(avm_read), 64'd1);
    check("zw_addr1", 64'(avm_address), 64'd0);
    check("zw_busy1", 64'(busy), 64'd1);
    @(negedge clock);
    check("zw_read2", 64'(avm_read), 64'd1);
    check("zw_addr2", 64'(avm_address), 64'd1);
    @(negedge clock);
    check("zw_read3", 64'(avm_read), 64'd0);
    check("zw_busy3", 64'(busy), 64'd1);
    drain();

    // three wait states on each read
    slave_ts = EXP_TS;
    stall_n  = 3;
    push_exp(0, 1'b0, 1'b1, 1'b1, 32'd0, EXP_TS);
    pulse_start(k);
    exp_q[exp_q.size()-1][82:67] = 16'(k + 10);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      check("ws_read", 64'(avm_read), 64'd1);
      check("ws_addr", 64'(avm_address), (i <= 4) ? 64'd0 : 64'd1);
    end
    drain();

    // timestamp read stuck: abort after 8 stalled cycles
    stall_n  = 0;
    stuck_ts = 1'b1;
    slave_id = 32'hA5A5_0001;
    push_exp(0, 1'b1, 1'b0, 1'b0, 32'hA5A5_0001, EXP_TS);
    pulse_start(k);
    exp_q[exp_q.size()-1][82:67] = 16'(k + 10);
    drain();
    check("tmo_read_after", 64'(avm_read), 64'd0);
    check("tmo_busy_after", 64'(busy), 64'd0);
    stuck_ts = 1'b0;
    slave_id = 32'd0;

    // start while busy and coincident with done is ignored; next one runs
    @(posedge clock); #1;
    k = cyc;
    push_exp(k + 4, 1'b0, 1'b1, 1'b1, 32'd0, EXP_TS);
    push_exp(k + 9, 1'b0, 1'b1, 1'b1, 32'd0, EXP_TS);
    for (int i = 0; i < 6; i++) begin
      start = (i == 0 || i == 2 || i == 4 || i == 5);
      @(posedge clock); #1;
    end
    start = 1'b0;
    drain();

    // reset during the timestamp read, then auto-start again
    slave_id = 32'h0000_00FF;
    pulse_start(k);
    @(posedge clock); #1;
    @(negedge clock);
    check("mid_addr", 64'(avm_address), 64'd1);
    check("mid_read", 64'(avm_read), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check_reset_state("mid_rst");
    slave_id = 32'd0;
    release_reset();
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
